// File: rtl/fb_plot_buffer.sv
// Pixel plot buffer: accepts (x, y, colour) beats, linearises the address and
// queues them in a show-ahead FIFO that drains into the framebuffer write port.
module fb_plot_buffer #(
   parameter int DEPTH   = 4,
   parameter int COLOR_W = 12,
   parameter int H_RES   = 160,
   parameter int V_RES   = 120,
   parameter int ADDR_W  = 15
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [7:0]         in_x,
   input  logic [7:0]         in_y,
   input  logic [COLOR_W-1:0] in_color,
   input  logic               in_last,
   output logic [ADDR_W-1:0]  fb_addr,
   output logic [COLOR_W-1:0] fb_data,
   output logic               fb_we,
   input  logic               fb_grant,
   output logic               frame_done,
   output logic [7:0]         oob_count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] ST_ACCEPT = 2'd0;
   localparam logic [1:0] ST_DRAIN  = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   logic [1:0]         state;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W:0]     count;
   logic [ADDR_W-1:0]  addr_mem [DEPTH];
   logic [COLOR_W-1:0] data_mem [DEPTH];

   logic              accept;
   logic              out_of_range;
   logic              push;
   logic              pop;
   logic [ADDR_W-1:0] lin_addr;

   assign in_ready     = (state == ST_ACCEPT) && (count < (PTR_W+1)'(DEPTH));
   assign accept       = in_valid && in_ready;
   assign out_of_range = (int'(in_x) >= H_RES) || (int'(in_y) >= V_RES);
   assign push         = accept && !out_of_range;
   assign pop          = fb_we && fb_grant;
   assign lin_addr     = ADDR_W'(in_y) * ADDR_W'(H_RES) + ADDR_W'(in_x);

   assign fb_we      = (count != '0);
   assign fb_addr    = addr_mem[rd_ptr];
   assign fb_data    = data_mem[rd_ptr];
   assign frame_done = (state == ST_DONE);

   // Storage carries no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr] <= lin_addr;
         data_mem[wr_ptr] <= in_color;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)
            count <= count + (PTR_W+1)'(1);
         else if (pop && !push)
            count <= count - (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         oob_count <= '0;
      else if (accept && out_of_range && oob_count != 8'hFF)
         oob_count <= oob_count + 8'd1;
   end

   // Frame end is declared only once the last queued entry has been retired.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_ACCEPT;
      end else begin
         case (state)
            ST_ACCEPT: if (accept && in_last) state <= ST_DRAIN;
            ST_DRAIN:  if (count == '0 || (count == (PTR_W+1)'(1) && pop)) state <= ST_DONE;
            ST_DONE:   state <= ST_ACCEPT;
            default:   state <= ST_ACCEPT;
         endcase
      end
   end

endmodule

// File: tb/tb_fb_plot_buffer.sv
// Bench for fb_plot_buffer: directed scenarios plus random traffic, checked
// every cycle against a queue-based behavioural model of the buffer.
module tb_fb_plot_buffer;

   localparam int DEPTH   = 4;
   localparam int COLOR_W = 12;
   localparam int H_RES   = 160;
   localparam int V_RES   = 120;
   localparam int ADDR_W  = 15;

   logic               clk = 1'b0;
   logic               reset;
   logic               in_valid;
   logic               in_ready;
   logic [7:0]         in_x;
   logic [7:0]         in_y;
   logic [COLOR_W-1:0] in_color;
   logic               in_last;
   logic [ADDR_W-1:0]  fb_addr;
   logic [COLOR_W-1:0] fb_data;
   logic               fb_we;
   logic               fb_grant;
   logic               frame_done;
   logic [7:0]         oob_count;

   fb_plot_buffer #(
      .DEPTH(DEPTH), .COLOR_W(COLOR_W), .H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_y(in_y), .in_color(in_color), .in_last(in_last),
      .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we), .fb_grant(fb_grant),
      .frame_done(frame_done), .oob_count(oob_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int addr;
      int data;
   } beat_t;

   // Reference model: pending writes as a queue, frame phase, discard counter.
   beat_t m_q[$];
   int    m_phase;
   int    m_oob;
   int    m_pushes;

   int compared   = 0;
   int mismatched = 0;
   int dut_writes = 0;
   int done_seen  = 0;
   int last_wr_addr = -1;

   task automatic checkOutput(input string tag, input int actual, input int expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // One clock cycle: compare outputs, drive new inputs, advance the model.
   task automatic applyStimulus(input logic rst, input logic v, input int x, input int y,
                                input int c, input logic last, input logic g,
                                output bit acc);
      int  sz;
      bit  m_ready;
      bit  m_pop;
      @(negedge clk);
      m_ready = (m_phase == 0) && (m_q.size() < DEPTH);
      checkOutput("in_ready", int'(in_ready), int'(m_ready));
      checkOutput("fb_we", int'(fb_we), int'(m_q.size() != 0));
      if (m_q.size() != 0) begin
         checkOutput("fb_addr", int'(fb_addr), m_q[0].addr);
         checkOutput("fb_data", int'(fb_data), m_q[0].data);
      end
      checkOutput("frame_done", int'(frame_done), int'(m_phase == 2));
      checkOutput("oob_count", int'(oob_count), m_oob);
      if (frame_done === 1'b1) done_seen++;

      reset    = rst;
      in_valid = v;
      in_x     = 8'(x);
      in_y     = 8'(y);
      in_color = COLOR_W'(c);
      in_last  = last;
      fb_grant = g;
      if (!rst && fb_we === 1'b1 && g) begin
         dut_writes++;
         last_wr_addr = int'(fb_addr);
      end

      acc = 1'b0;
      if (rst) begin
         m_q.delete();
         m_phase = 0;
         m_oob   = 0;
      end else begin
         sz    = m_q.size();
         m_pop = (sz != 0) && g;
         acc   = v && m_ready;
         case (m_phase)
            0: if (acc && last) m_phase = 1;
            1: if (sz == 0 || (sz == 1 && m_pop)) m_phase = 2;
            default: m_phase = 0;
         endcase
         if (m_pop) void'(m_q.pop_front());
         if (acc) begin
            if (x < H_RES && y < V_RES) begin
               m_q.push_back('{addr: y * H_RES + x, data: c});
               m_pushes++;
            end else if (m_oob < 255) begin
               m_oob++;
            end
         end
      end
   endtask

   task automatic idle(input int n, input logic g);
      bit acc;
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b0, g, acc);
   endtask

   // Holds a beat on the input until accepted, bounded by a cycle budget.
   task automatic sendBeat(input int x, input int y, input int c, input logic last,
                           input logic g, input int budget);
      bit acc;
      int k;
      k = 0;
      acc = 1'b0;
      while (!acc && k < budget) begin
         applyStimulus(1'b0, 1'b1, x, y, c, last, g, acc);
         k++;
      end
      if (!acc) checkOutput("accept_timeout", 0, 1);
   endtask

   initial begin
      bit acc;
      int wr_before;
      int done_before;
      int push_before;
      int n_acc;
      int cycles;
      m_phase  = 0;
      m_oob    = 0;
      m_pushes = 0;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_x     = '0;
      in_y     = '0;
      in_color = '0;
      in_last  = 1'b0;
      fb_grant = 1'b0;
      repeat (2) @(posedge clk);

      $display("[TB] reset state");
      applyStimulus(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b1, acc);
      idle(2, 1'b1);

      $display("[TB] single pixel");
      applyStimulus(1'b0, 1'b1, 3, 2, 12'hABC, 1'b0, 1'b1, acc);
      applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1, acc);
      checkOutput("single_addr", last_wr_addr, 323);
      idle(3, 1'b1);

      $display("[TB] backpressure");
      wr_before = dut_writes;
      for (int i = 0; i < 4; i++) sendBeat(i, 0, 16 + i, 1'b0, 1'b0, 5);
      for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 4, 0, 20, 1'b0, 1'b0, acc);
      checkOutput("bp_held", int'(acc), 0);
      sendBeat(4, 0, 20, 1'b0, 1'b1, 10);
      idle(8, 1'b1);
      checkOutput("bp_writes", dut_writes - wr_before, 5);
      checkOutput("bp_last_addr", last_wr_addr, 4);

      $display("[TB] full sweep");
      wr_before   = dut_writes;
      done_before = done_seen;
      for (int y = 0; y < V_RES; y++)
         for (int x = 0; x < H_RES; x++)
            sendBeat(x, y, (x ^ y) & 12'hFFF, (x == H_RES - 1) && (y == V_RES - 1), 1'b1, 10);
      idle(8, 1'b1);
      checkOutput("sweep_writes", dut_writes - wr_before, H_RES * V_RES);
      checkOutput("sweep_last_addr", last_wr_addr, H_RES * V_RES - 1);
      checkOutput("sweep_done", done_seen - done_before, 1);

      $display("[TB] out of range");
      wr_before = dut_writes;
      sendBeat(160, 0, 1, 1'b0, 1'b1, 5);
      sendBeat(0, 120, 2, 1'b0, 1'b1, 5);
      sendBeat(255, 255, 3, 1'b0, 1'b1, 5);
      idle(2, 1'b1);
      checkOutput("oob_three", int'(oob_count), 3);
      for (int i = 0; i < 300; i++) sendBeat(200 + (i % 50), i % 256, i, 1'b0, 1'b1, 5);
      idle(1, 1'b1);
      checkOutput("oob_saturate", int'(oob_count), 255);
      done_before = done_seen;
      sendBeat(170, 3, 0, 1'b1, 1'b1, 5);
      idle(5, 1'b1);
      checkOutput("oob_writes", dut_writes - wr_before, 0);
      checkOutput("oob_last_done", done_seen - done_before, 1);

      $display("[TB] reset mid-drain");
      done_before = done_seen;
      sendBeat(10, 5, 7, 1'b0, 1'b0, 5);
      sendBeat(11, 5, 8, 1'b0, 1'b0, 5);
      sendBeat(12, 5, 9, 1'b1, 1'b0, 5);
      idle(2, 1'b0);
      applyStimulus(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, acc);
      idle(3, 1'b0);
      idle(5, 1'b1);
      checkOutput("rst_no_done", done_seen - done_before, 0);
      checkOutput("rst_oob_clear", int'(oob_count), 0);

      $display("[TB] random concurrency");
      wr_before   = dut_writes;
      push_before = m_pushes;
      n_acc  = 0;
      cycles = 0;
      while (n_acc < 10000 && cycles < 40000) begin
         applyStimulus(1'b0, ($urandom % 4) != 0, $urandom_range(0, 165), $urandom_range(0, 123),
                       $urandom_range(0, 4095), ($urandom % 300) == 0, ($urandom % 3) != 0, acc);
         if (acc) n_acc++;
         cycles++;
      end
      if (n_acc < 10000) checkOutput("rand_timeout", n_acc, 10000);
      idle(20, 1'b1);
      checkOutput("rand_writes", dut_writes - wr_before, m_pushes - push_before);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
